// File: rtl/bytecode_fetch_if.sv
// Fetch-unit bus: program-memory read port plus the instruction handshake
// toward control. The fetch unit is the master.
interface bytecode_fetch_if #(parameter int ADDR_W = 16);
   logic              start;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic [7:0]        mem_data;
   logic [7:0]        op_code;
   logic [7:0]        arg1;
   logic [7:0]        arg2;
   logic              op_valid;
   logic              op_done;
   logic [15:0]       offset;
   logic [ADDR_W-1:0] pc;
   logic              halted;

   modport master (
      input  start, mem_data, op_done, offset,
      output mem_addr, mem_rd, op_code, arg1, arg2, op_valid, pc, halted
   );

   modport slave (
      output start, mem_data, op_done, offset,
      input  mem_addr, mem_rd, op_code, arg1, arg2, op_valid, pc, halted
   );
endinterface

// File: rtl/bytecode_fetch.sv
// Bytecode fetch unit: reads a 1-3 byte instruction one byte per two cycles,
// presents it to control, then advances pc by length or by a branch offset.
module bytecode_fetch #(
   parameter int ADDR_W = 16
) (
   input logic            clk,
   input logic            rst_n,
   bytecode_fetch_if.master bus
);

   typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ISSUE, HALT} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] pc_q, pc_nx;
   logic [1:0]        k_q, k_nx;
   logic [7:0]        op_q, op_nx;
   logic [7:0]        a1_q, a1_nx;
   logic [7:0]        a2_q, a2_nx;
   logic [1:0]        cur_len;

   function automatic logic [1:0] op_len(input logic [7:0] op);
      if (op == 8'h11 || op == 8'h84 || (op >= 8'h99 && op <= 8'hA7))
         return 2'd3;
      else if (op == 8'h10 || op == 8'h12 || op == 8'h15 || op == 8'h36)
         return 2'd2;
      else
         return 2'd1;
   endfunction

   // While capturing the opcode itself, decode length straight off the bus.
   assign cur_len = op_len((k_q == 2'd0) ? bus.mem_data : op_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pc_q  <= '0;
         k_q   <= '0;
         op_q  <= '0;
         a1_q  <= '0;
         a2_q  <= '0;
      end else begin
         state <= state_nx;
         pc_q  <= pc_nx;
         k_q   <= k_nx;
         op_q  <= op_nx;
         a1_q  <= a1_nx;
         a2_q  <= a2_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pc_nx    = pc_q;
      k_nx     = k_q;
      op_nx    = op_q;
      a1_nx    = a1_q;
      a2_nx    = a2_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               pc_nx    = '0;
               k_nx     = '0;
               state_nx = FETCH;
            end
         end
         FETCH: state_nx = CAPTURE;
         CAPTURE: begin
            case (k_q)
               2'd0: begin
                  op_nx = bus.mem_data;
                  a1_nx = '0;
                  a2_nx = '0;
               end
               2'd1:    a1_nx = bus.mem_data;
               default: a2_nx = bus.mem_data;
            endcase
            if ((3'(k_q) + 3'd1) < 3'(cur_len)) begin
               k_nx     = k_q + 2'd1;
               state_nx = FETCH;
            end else begin
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.op_done) begin
               if (op_q == 8'hB1) begin
                  state_nx = HALT;
               end else begin
                  k_nx     = '0;
                  state_nx = FETCH;
                  // Offset is a signed byte delta; the size cast sign-extends or truncates to ADDR_W.
                  if (bus.offset != 16'd0)
                     pc_nx = pc_q + ADDR_W'($signed(bus.offset));
                  else
                     pc_nx = pc_q + ADDR_W'(op_len(op_q));
               end
            end
         end
         HALT:    state_nx = HALT;
         default: state_nx = IDLE;
      endcase
   end

   assign bus.mem_rd   = (state == FETCH);
   assign bus.mem_addr = (state == FETCH) ? pc_q + ADDR_W'(k_q) : '0;
   assign bus.op_code  = op_q;
   assign bus.arg1     = a1_q;
   assign bus.arg2     = a2_q;
   assign bus.op_valid = (state == ISSUE);
   assign bus.pc       = pc_q;
   assign bus.halted   = (state == HALT);

endmodule

// File: tb/tb_bytecode_fetch.sv
// Bench for bytecode_fetch: directed scenarios plus randomized traffic, all
// checked every cycle against a cycle-count reference of the fetch protocol.
module tb_bytecode_fetch;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bytecode_fetch_if #(.ADDR_W(16)) bus ();
   bytecode_fetch_if #(.ADDR_W(4))  bus4 ();

   bytecode_fetch #(.ADDR_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   bytecode_fetch #(.ADDR_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

   logic [7:0] mem  [0:65535];
   logic [7:0] mem4 [0:15];

   always @(posedge clk) begin
      if (bus.mem_rd)  bus.mem_data  <= mem[bus.mem_addr];
      if (bus4.mem_rd) bus4.mem_data <= mem4[bus4.mem_addr];
   end

   int n_chk  = 0;
   int n_fail = 0;

   // Reference: an instruction at m_pc of length L spends 2L cycles being fetched
   // (even cycles read byte c/2), then is presented until op_done.
   typedef enum {M_IDLE, M_RUN, M_HALT} mmode_t;
   mmode_t      m_mode;
   logic [15:0] m_pc;
   int          m_c;

   function automatic int ref_len(input logic [7:0] b);
      case (b) inside
         8'h11, 8'h84, [8'h99:8'hA7]: return 3;
         8'h10, 8'h12, 8'h15, 8'h36:  return 2;
         default:                     return 1;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode <= M_IDLE;
         m_pc   <= '0;
         m_c    <= 0;
      end else begin
         case (m_mode)
            M_IDLE: if (bus.start) begin
               m_mode <= M_RUN;
               m_pc   <= '0;
               m_c    <= 0;
            end
            M_RUN: begin
               if (m_c < 2 * ref_len(mem[m_pc]))
                  m_c <= m_c + 1;
               else if (bus.op_done) begin
                  if (mem[m_pc] == 8'hB1)
                     m_mode <= M_HALT;
                  else begin
                     m_c  <= 0;
                     m_pc <= (bus.offset != 16'd0) ? m_pc + bus.offset
                                                   : m_pc + 16'(ref_len(mem[m_pc]));
                  end
               end
            end
            default: ;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare();
      int L;
      L = ref_len(mem[m_pc]);
      chk("halted", 32'(bus.halted), 32'(m_mode == M_HALT));
      case (m_mode)
         M_IDLE: begin
            chk("idle_mem_rd",   32'(bus.mem_rd),   32'd0);
            chk("idle_op_valid", 32'(bus.op_valid), 32'd0);
            chk("idle_mem_addr", 32'(bus.mem_addr), 32'd0);
            chk("idle_pc",       32'(bus.pc),       32'd0);
            chk("idle_op_code",  32'(bus.op_code),  32'd0);
            chk("idle_arg1",     32'(bus.arg1),     32'd0);
            chk("idle_arg2",     32'(bus.arg2),     32'd0);
         end
         M_HALT: begin
            chk("halt_mem_rd",   32'(bus.mem_rd),   32'd0);
            chk("halt_op_valid", 32'(bus.op_valid), 32'd0);
         end
         default: begin
            if (m_c < 2 * L) begin
               chk("fetch_op_valid", 32'(bus.op_valid), 32'd0);
               chk("fetch_mem_rd",   32'(bus.mem_rd),   32'(m_c % 2 == 0));
               if (m_c % 2 == 0)
                  chk("fetch_mem_addr", 32'(bus.mem_addr), 32'(16'(m_pc + 16'(m_c / 2))));
            end else begin
               chk("issue_op_valid", 32'(bus.op_valid), 32'd1);
               chk("issue_mem_rd",   32'(bus.mem_rd),   32'd0);
               chk("issue_pc",       32'(bus.pc),       32'(m_pc));
               chk("issue_op_code",  32'(bus.op_code),  32'(mem[m_pc]));
               chk("issue_arg1", 32'(bus.arg1), (L >= 2) ? 32'(mem[m_pc + 16'd1]) : 32'd0);
               chk("issue_arg2", 32'(bus.arg2), (L == 3) ? 32'(mem[m_pc + 16'd2]) : 32'd0);
            end
         end
      endcase
   endtask

   task automatic step();
      @(negedge clk);
      #2;
      compare();
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 16; i++) begin
         mem[i]  = 8'h00;
         mem4[i] = 8'h00;
      end
   endtask

   task automatic release_reset();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic start_run();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic wait_valid(input string nm, output int cyc);
      cyc = 0;
      while (!bus.op_valid && cyc < 40) begin
         step();
         cyc++;
      end
      if (!bus.op_valid) chk(nm, 32'(bus.op_valid), 32'd1);
   endtask

   task automatic done(input logic [15:0] off);
      bus.op_done = 1'b1;
      bus.offset  = off;
      step();
      bus.op_done = 1'b0;
      bus.offset  = 16'd0;
   endtask

   task automatic wait_valid4();
      int c;
      c = 0;
      while (!bus4.op_valid && c < 40) begin
         step();
         c++;
      end
      if (!bus4.op_valid) chk("w4_timeout", 32'(bus4.op_valid), 32'd1);
   endtask

   task automatic done4(input logic [15:0] off);
      bus4.op_done = 1'b1;
      bus4.offset  = off;
      step();
      bus4.op_done = 1'b0;
      bus4.offset  = 16'd0;
   endtask

   initial begin
      int cyc;
      int halt_cnt;
      logic [7:0] exp32 [3];
      logic [31:0] r;
      exp32 = '{8'h04, 8'h3C, 8'hB1};
      bus.start  = 1'b0; bus.op_done  = 1'b0; bus.offset  = 16'd0;
      bus4.start = 1'b0; bus4.op_done = 1'b0; bus4.offset = 16'd0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      rst_n = 1'b1;
      #1;
      hold_reset();
      chk("rst_mem_rd",   32'(bus.mem_rd),   32'd0);
      chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
      chk("rst_halted",   32'(bus.halted),   32'd0);
      chk("rst_pc",       32'(bus.pc),       32'd0);

      // three 1-byte instructions ending in return
      mem[0] = 8'h04; mem[1] = 8'h3C; mem[2] = 8'hB1;
      release_reset();
      step();
      chk("idle_wait_mem_rd", 32'(bus.mem_rd), 32'd0);
      start_run();
      for (int n = 0; n < 3; n++) begin
         wait_valid("t32_timeout", cyc);
         chk("t32_op_code", 32'(bus.op_code), 32'(exp32[n]));
         chk("t32_pc",      32'(bus.pc),      32'(n));
         step();
         done(16'd0);
      end
      for (int n = 0; n < 4; n++) begin
         chk("t32_halted", 32'(bus.halted), 32'd1);
         chk("t32_no_rd",  32'(bus.mem_rd), 32'd0);
         step();
      end

      // 2-byte instruction latency and operand clearing
      hold_reset();
      mem[0] = 8'h10; mem[1] = 8'h7F; mem[2] = 8'h05;
      release_reset();
      start_run();
      chk("t33_first_rd", 32'(bus.mem_rd), 32'd1);
      wait_valid("t33_timeout", cyc);
      chk("t33_latency", 32'(cyc),         32'd4);
      chk("t33_op_code", 32'(bus.op_code), 32'h10);
      chk("t33_arg1",    32'(bus.arg1),    32'h7F);
      chk("t33_arg2",    32'(bus.arg2),    32'h00);
      done(16'd0);
      chk("t33_next_addr", 32'(bus.mem_addr), 32'd2);
      chk("t33_next_rd",   32'(bus.mem_rd),   32'd1);

      // branch backward and forward from a goto at pc=5
      hold_reset();
      mem[5] = 8'hA7; mem[6] = 8'hFF; mem[7] = 8'hFB;
      release_reset();
      start_run();
      wait_valid("t34_timeout", cyc);
      done(16'd5);
      wait_valid("t34_timeout", cyc);
      chk("t34_pc",   32'(bus.pc),      32'd5);
      chk("t34_op",   32'(bus.op_code), 32'hA7);
      chk("t34_arg1", 32'(bus.arg1),    32'hFF);
      chk("t34_arg2", 32'(bus.arg2),    32'hFB);
      done(16'hFFFB);
      chk("t34_back_addr", 32'(bus.mem_addr), 32'd0);
      wait_valid("t34_timeout", cyc);
      chk("t34_cleared_arg1", 32'(bus.arg1), 32'd0);
      chk("t34_cleared_arg2", 32'(bus.arg2), 32'd0);
      done(16'd5);
      wait_valid("t34_timeout", cyc);
      done(16'd3);
      chk("t34_fwd_addr", 32'(bus.mem_addr), 32'd8);

      // reset while capturing arg1
      hold_reset();
      mem[0] = 8'h10; mem[1] = 8'h55;
      release_reset();
      start_run();
      step(); step(); step();
      rst_n = 1'b0;
      #1;
      chk("t36_op_code",  32'(bus.op_code),  32'd0);
      chk("t36_arg1",     32'(bus.arg1),     32'd0);
      chk("t36_mem_rd",   32'(bus.mem_rd),   32'd0);
      chk("t36_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("t36_op_valid", 32'(bus.op_valid), 32'd0);
      chk("t36_pc",       32'(bus.pc),       32'd0);
      step();
      rst_n = 1'b1;
      step();
      start_run();
      chk("t36_refetch_addr", 32'(bus.mem_addr), 32'd0);
      chk("t36_refetch_rd",   32'(bus.mem_rd),   32'd1);
      wait_valid("t36_timeout", cyc);
      chk("t36_arg1_again", 32'(bus.arg1), 32'h55);

      // stray op_done during fetch, stray start during issue
      hold_reset();
      mem[0] = 8'h10; mem[1] = 8'h22;
      release_reset();
      bus.op_done = 1'b1;
      start_run();
      wait_valid("t37_timeout", cyc);
      bus.op_done = 1'b0;
      chk("t37_latency", 32'(cyc), 32'd4);
      bus.start = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("t37_hold_valid", 32'(bus.op_valid), 32'd1);
         chk("t37_hold_op",    32'(bus.op_code),  32'h10);
      end
      bus.start = 1'b0;
      done(16'd0);
      chk("t37_next_addr", 32'(bus.mem_addr), 32'd2);

      // 4-bit address space wraps
      hold_reset();
      release_reset();
      bus4.start = 1'b1;
      step();
      bus4.start = 1'b0;
      wait_valid4();
      done4(16'h000F);
      wait_valid4();
      chk("t35_pc15", 32'(bus4.pc), 32'd15);
      done4(16'h0000);
      chk("t35_wrap_addr", 32'(bus4.mem_addr), 32'd0);
      chk("t35_wrap_rd",   32'(bus4.mem_rd),   32'd1);
      wait_valid4();
      done4(16'hFFFF);
      chk("t35_neg_addr", 32'(bus4.mem_addr), 32'd15);

      // randomized traffic over a random program image
      hold_reset();
      for (int i = 0; i < 65536; i++) begin
         r = $urandom;
         mem[i] = (r % 32 == 0) ? 8'hB1 : r[15:8];
      end
      release_reset();
      halt_cnt = 0;
      for (int c = 0; c < 4000; c++) begin
         bus.start   = ($urandom % 4 == 0);
         bus.op_done = ($urandom % 3 == 0);
         if ($urandom % 20 == 0)
            bus.offset = 16'($urandom);
         else if ($urandom % 3 == 0)
            bus.offset = 16'($urandom_range(0, 40)) - 16'd20;
         else
            bus.offset = 16'd0;
         if (bus.halted) halt_cnt++;
         if (halt_cnt > 5 || $urandom % 400 == 0) begin
            halt_cnt = 0;
            rst_n = 1'b0;
            #1;
            step();
            rst_n = 1'b1;
         end else begin
            step();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
